// File: rtl/icache_miss_handler.sv
// Single-entry icache miss handler: issues one L2 line read per F2 miss, waits for the
// matching response (re-issuing on timeout) and hands the line to the icache fill path.
module icache_miss_handler #(
  parameter int CACHE_LINE = 512,
  parameter int ADDR_SZ    = 32,
  parameter int TIMEOUT    = 255
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  f2_miss_valid,
  input  logic [ADDR_SZ-1:0]    f2_miss_p_addr,
  input  logic [ADDR_SZ-1:0]    f2_miss_v_addr,
  input  logic                  f2_redirect,
  output logic                  mh_busy,
  output logic [2:0]            icache_l2_op,
  output logic [ADDR_SZ-1:0]    icache_l2_addr,
  input  logic                  l2_icache_ready,
  input  logic [2:0]            l2_icache_op,
  input  logic [ADDR_SZ-1:0]    l2_icache_addr,
  input  logic [CACHE_LINE-1:0] l2_icache_data,
  input  logic [3:0]            l2_icache_state,
  output logic                  fill_valid,
  output logic [ADDR_SZ-1:0]    fill_p_addr,
  output logic [ADDR_SZ-1:0]    fill_v_addr,
  output logic [CACHE_LINE-1:0] fill_data,
  output logic [3:0]            fill_state,
  output logic                  fill_replay,
  output logic [3:0]            retry_cnt
);

  localparam int OFS = $clog2(CACHE_LINE / 8);
  localparam int TW  = $clog2(TIMEOUT + 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] REQ  = 2'd1;
  localparam logic [1:0] WAIT = 2'd2;
  localparam logic [1:0] FILL = 2'd3;

  localparam logic [2:0] OP_NOP = 3'd0;
  localparam logic [2:0] OP_R   = 3'd1;

  localparam logic [ADDR_SZ-1:0] LINE_MASK = ~(ADDR_SZ'((64'd1 << OFS) - 64'd1));

  logic [1:0]            state_q, state_d;
  logic [ADDR_SZ-1:0]    line_addr_q, line_addr_d;
  logic [ADDR_SZ-1:0]    v_addr_q, v_addr_d;
  logic                  cancel_q, cancel_d;
  logic                  first_q, first_d;
  logic [TW-1:0]         timer_q, timer_d;
  logic [3:0]            retry_q, retry_d;
  logic [ADDR_SZ-1:0]    fill_p_q, fill_p_d;
  logic [ADDR_SZ-1:0]    fill_v_q, fill_v_d;
  logic [CACHE_LINE-1:0] fill_data_q, fill_data_d;
  logic [3:0]            fill_state_q, fill_state_d;
  logic                  resp_match;

  // Only the line-number bits take part in the response match.
  assign resp_match = (l2_icache_op == OP_R) &&
                      (((l2_icache_addr ^ line_addr_q) & LINE_MASK) == '0);

  always_comb begin
    state_d      = state_q;
    line_addr_d  = line_addr_q;
    v_addr_d     = v_addr_q;
    cancel_d     = cancel_q;
    first_d      = first_q;
    timer_d      = timer_q;
    retry_d      = retry_q;
    fill_p_d     = fill_p_q;
    fill_v_d     = fill_v_q;
    fill_data_d  = fill_data_q;
    fill_state_d = fill_state_q;
    case (state_q)
      IDLE: begin
        if (f2_miss_valid && !f2_redirect) begin
          state_d     = REQ;
          line_addr_d = f2_miss_p_addr & LINE_MASK;
          v_addr_d    = f2_miss_v_addr;
          cancel_d    = 1'b0;
          first_d     = 1'b1;
          timer_d     = '0;
          retry_d     = 4'd0;
        end
      end
      REQ: begin
        if (l2_icache_ready) begin
          state_d = WAIT;
          timer_d = '0;
          first_d = 1'b0;
          if (f2_redirect) cancel_d = 1'b1;
        end else if (f2_redirect) begin
          // Nothing has reached L2 yet on the first issue, so the miss can simply be dropped.
          if (first_q) state_d = IDLE;
          else         cancel_d = 1'b1;
        end
      end
      WAIT: begin
        timer_d = timer_q + TW'(1);
        if (f2_redirect) cancel_d = 1'b1;
        if (resp_match) begin
          state_d      = FILL;
          fill_p_d     = line_addr_q;
          fill_v_d     = v_addr_q;
          fill_data_d  = l2_icache_data;
          fill_state_d = l2_icache_state;
        end else if (timer_q == TW'(TIMEOUT - 1)) begin
          state_d = REQ;
          if (retry_q != 4'hf) retry_d = retry_q + 4'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      line_addr_q  <= '0;
      v_addr_q     <= '0;
      cancel_q     <= 1'b0;
      first_q      <= 1'b0;
      timer_q      <= '0;
      retry_q      <= 4'd0;
      fill_p_q     <= '0;
      fill_v_q     <= '0;
      fill_data_q  <= '0;
      fill_state_q <= 4'd0;
    end else begin
      state_q      <= state_d;
      line_addr_q  <= line_addr_d;
      v_addr_q     <= v_addr_d;
      cancel_q     <= cancel_d;
      first_q      <= first_d;
      timer_q      <= timer_d;
      retry_q      <= retry_d;
      fill_p_q     <= fill_p_d;
      fill_v_q     <= fill_v_d;
      fill_data_q  <= fill_data_d;
      fill_state_q <= fill_state_d;
    end
  end

  assign mh_busy        = (state_q != IDLE);
  assign icache_l2_op   = (state_q == REQ) ? OP_R : OP_NOP;
  assign icache_l2_addr = line_addr_q;
  assign fill_valid     = (state_q == FILL);
  assign fill_replay    = fill_valid & ~cancel_q & ~f2_redirect;
  assign fill_p_addr    = fill_p_q;
  assign fill_v_addr    = fill_v_q;
  assign fill_data      = fill_data_q;
  assign fill_state     = fill_state_q;
  assign retry_cnt      = retry_q;

endmodule

// File: tb/tb_icache_miss_handler.sv
// Directed bench for icache_miss_handler: vector table for the short flows plus
// hand-written timeout and asynchronous-reset sequences.
module tb_icache_miss_handler;

  logic         clk = 1'b0;
  logic         rst;
  logic         f2_miss_valid;
  logic [31:0]  f2_miss_p_addr;
  logic [31:0]  f2_miss_v_addr;
  logic         f2_redirect;
  logic         mh_busy;
  logic [2:0]   icache_l2_op;
  logic [31:0]  icache_l2_addr;
  logic         l2_icache_ready;
  logic [2:0]   l2_icache_op;
  logic [31:0]  l2_icache_addr;
  logic [511:0] l2_icache_data;
  logic [3:0]   l2_icache_state;
  logic         fill_valid;
  logic [31:0]  fill_p_addr;
  logic [31:0]  fill_v_addr;
  logic [511:0] fill_data;
  logic [3:0]   fill_state;
  logic         fill_replay;
  logic [3:0]   retry_cnt;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  icache_miss_handler dut (
    .clk(clk), .rst(rst),
    .f2_miss_valid(f2_miss_valid), .f2_miss_p_addr(f2_miss_p_addr),
    .f2_miss_v_addr(f2_miss_v_addr), .f2_redirect(f2_redirect),
    .mh_busy(mh_busy), .icache_l2_op(icache_l2_op), .icache_l2_addr(icache_l2_addr),
    .l2_icache_ready(l2_icache_ready), .l2_icache_op(l2_icache_op),
    .l2_icache_addr(l2_icache_addr), .l2_icache_data(l2_icache_data),
    .l2_icache_state(l2_icache_state),
    .fill_valid(fill_valid), .fill_p_addr(fill_p_addr), .fill_v_addr(fill_v_addr),
    .fill_data(fill_data), .fill_state(fill_state), .fill_replay(fill_replay),
    .retry_cnt(retry_cnt)
  );

  typedef struct {
    logic        miss;
    logic [31:0] p;
    logic        redir;
    logic        rdy;
    logic [2:0]  l2op;
    logic [31:0] l2a;
    logic        busy;
    logic [2:0]  op;
    logic [31:0] l2addr;
    logic        fv;
    logic        replay;
    logic [31:0] fpa;
    logic [31:0] fva;
  } vec_t;

  vec_t vecs[$];

  function automatic logic [511:0] make_line(input logic [31:0] a);
    return {16{a ^ 32'h5A5A_0000}};
  endfunction

  function automatic vec_t mk(input logic miss, input logic [31:0] p, input logic redir,
                              input logic rdy, input logic [2:0] l2op, input logic [31:0] l2a,
                              input logic busy, input logic [2:0] op, input logic [31:0] l2addr,
                              input logic fv, input logic replay, input logic [31:0] fpa,
                              input logic [31:0] fva);
    vec_t v;
    v.miss = miss; v.p = p; v.redir = redir; v.rdy = rdy; v.l2op = l2op; v.l2a = l2a;
    v.busy = busy; v.op = op; v.l2addr = l2addr; v.fv = fv; v.replay = replay;
    v.fpa = fpa; v.fva = fva;
    return v;
  endfunction

  task automatic check(input string name, input logic [511:0] act, input logic [511:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic miss, input logic [31:0] p, input logic redir,
                       input logic rdy, input logic [2:0] l2op, input logic [31:0] l2a);
    f2_miss_valid   = miss;
    f2_miss_p_addr  = p;
    f2_miss_v_addr  = p ^ 32'hC000_0000;
    f2_redirect     = redir;
    l2_icache_ready = rdy;
    l2_icache_op    = l2op;
    l2_icache_addr  = l2a;
    l2_icache_data  = make_line(l2a);
    l2_icache_state = l2a[9:6];
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int n;
    rst = 1'b0;
    drive(0, 0, 0, 0, 0, 0);
    repeat (2) @(posedge clk);
    #1;
    check("reset_busy", 512'(mh_busy), 512'(0));
    check("reset_op", 512'(icache_l2_op), 512'(0));
    check("reset_l2addr", 512'(icache_l2_addr), 512'(0));
    check("reset_fill_valid", 512'(fill_valid), 512'(0));
    check("reset_fill_data", fill_data, 512'(0));
    check("reset_retry", 512'(retry_cnt), 512'(0));
    @(negedge clk);
    rst = 1'b1;

    // basic miss
    vecs.push_back(mk(1, 32'h0000_1234, 0, 0, 0, 0,            1, 1, 32'h0000_1200, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 1, 0, 0,                        1, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0,                        1, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0,                        1, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 1, 32'h0000_1200,            1, 0, 0, 1, 1, 32'h0000_1200, 32'hC000_1234));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0,                        0, 0, 0, 0, 0, 0, 0));
    // backpressure + mismatching response
    vecs.push_back(mk(1, 32'h0000_1234, 0, 0, 0, 0,            1, 1, 32'h0000_1200, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0,                        1, 1, 32'h0000_1200, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0,                        1, 1, 32'h0000_1200, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0,                        1, 1, 32'h0000_1200, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0,                        1, 1, 32'h0000_1200, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 1, 0, 0,                        1, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 1, 32'h0000_1240,            1, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 2, 32'h0000_1200,            1, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 1, 32'h0000_1200,            1, 0, 0, 1, 1, 32'h0000_1200, 32'hC000_1234));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0,                        0, 0, 0, 0, 0, 0, 0));
    // miss and redirect together in IDLE
    vecs.push_back(mk(1, 32'h4000_0000, 1, 0, 0, 0,            0, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0,                        0, 0, 0, 0, 0, 0, 0));
    // redirect during WAIT
    vecs.push_back(mk(1, 32'h0000_ABCD, 0, 0, 0, 0,            1, 1, 32'h0000_ABC0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 1, 0, 0,                        1, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 1, 0, 0, 0,                        1, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 1, 32'h0000_ABC0,            1, 0, 0, 1, 0, 32'h0000_ABC0, 32'hC000_ABCD));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0,                        0, 0, 0, 0, 0, 0, 0));
    // redirect on first REQ cycle, then a stray response while idle
    vecs.push_back(mk(1, 32'h3000_0080, 0, 0, 0, 0,            1, 1, 32'h3000_0080, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 1, 0, 0, 0,                        0, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 1, 32'h3000_0080,            0, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 1, 0, 0,                        0, 0, 0, 0, 0, 0, 0));

    foreach (vecs[i]) begin
      drive(vecs[i].miss, vecs[i].p, vecs[i].redir, vecs[i].rdy, vecs[i].l2op, vecs[i].l2a);
      tick();
      $display("vec %0d: busy=%0d op=%0d fill_valid=%0d replay=%0d", i, mh_busy, icache_l2_op,
               fill_valid, fill_replay);
      check($sformatf("v%0d_busy", i), 512'(mh_busy), 512'(vecs[i].busy));
      check($sformatf("v%0d_op", i), 512'(icache_l2_op), 512'(vecs[i].op));
      if (vecs[i].op == 3'd1)
        check($sformatf("v%0d_l2addr", i), 512'(icache_l2_addr), 512'(vecs[i].l2addr));
      check($sformatf("v%0d_fill_valid", i), 512'(fill_valid), 512'(vecs[i].fv));
      check($sformatf("v%0d_replay", i), 512'(fill_replay), 512'(vecs[i].replay));
      if (vecs[i].fv) begin
        check($sformatf("v%0d_fill_p", i), 512'(fill_p_addr), 512'(vecs[i].fpa));
        check($sformatf("v%0d_fill_v", i), 512'(fill_v_addr), 512'(vecs[i].fva));
        check($sformatf("v%0d_fill_data", i), fill_data, make_line(vecs[i].fpa));
        check($sformatf("v%0d_fill_state", i), 512'(fill_state), 512'(vecs[i].fpa[9:6]));
      end
    end

    // timeout: no response for TIMEOUT WAIT cycles
    drive(1, 32'h2000_0040, 0, 0, 0, 0);
    tick();
    drive(0, 0, 0, 1, 0, 0);
    tick();
    check("to_enter_wait_op", 512'(icache_l2_op), 512'(0));
    drive(0, 0, 0, 0, 0, 0);
    n = 0;
    while (icache_l2_op != 3'd1 && n < 1000) begin
      tick();
      n++;
    end
    $display("timeout: reissue after %0d cycles, retry_cnt=%0d", n, retry_cnt);
    check("to_wait_cycles", 512'(n), 512'(255));
    check("to_retry_cnt", 512'(retry_cnt), 512'(1));
    check("to_l2addr", 512'(icache_l2_addr), 512'(32'h2000_0040));
    drive(0, 0, 0, 1, 0, 0);
    tick();
    drive(0, 0, 0, 0, 1, 32'h2000_0040);
    tick();
    check("to_fill_valid", 512'(fill_valid), 512'(1));
    check("to_fill_replay", 512'(fill_replay), 512'(1));
    check("to_fill_p", 512'(fill_p_addr), 512'(32'h2000_0040));
    check("to_fill_v", 512'(fill_v_addr), 512'(32'hE000_0040));
    check("to_fill_retry", 512'(retry_cnt), 512'(1));
    drive(0, 0, 0, 0, 0, 0);
    tick();
    check("to_busy_low", 512'(mh_busy), 512'(0));

    // asynchronous reset during WAIT
    drive(1, 32'h5000_1100, 0, 0, 0, 0);
    tick();
    drive(0, 0, 0, 1, 0, 0);
    tick();
    drive(0, 0, 0, 0, 0, 0);
    tick();
    check("rw_busy_before", 512'(mh_busy), 512'(1));
    #2;
    rst = 1'b0;
    #1;
    $display("reset mid-wait: busy=%0d fill_p=%0h retry=%0d", mh_busy, fill_p_addr, retry_cnt);
    check("rw_busy", 512'(mh_busy), 512'(0));
    check("rw_op", 512'(icache_l2_op), 512'(0));
    check("rw_l2addr", 512'(icache_l2_addr), 512'(0));
    check("rw_fill_p", 512'(fill_p_addr), 512'(0));
    check("rw_fill_v", 512'(fill_v_addr), 512'(0));
    check("rw_fill_data", fill_data, 512'(0));
    check("rw_retry", 512'(retry_cnt), 512'(0));
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    drive(0, 0, 0, 0, 1, 32'h5000_1100);
    tick();
    check("rw_late_resp_fv", 512'(fill_valid), 512'(0));
    check("rw_late_resp_busy", 512'(mh_busy), 512'(0));
    drive(0, 0, 0, 0, 0, 0);
    tick();
    check("rw_after_fv", 512'(fill_valid), 512'(0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/icache_miss_handler.md
Name: icache_miss_handler

Overview:
- Single-entry miss handler between the icache F2 stage and L2.
- On an F2 miss it issues one line read to L2, waits for the matching response and returns the line to the icache fill path.
- It holds the fetch stages stalled while busy, tolerates a front-end redirect mid-miss, and re-issues the read if L2 does not answer within a timeout.

Parameters:
- CACHE_LINE, 512, line width in bits; line offset bits OFS = $clog2(CACHE_LINE/8) = 6.
- ADDR_SZ, 32, physical/virtual address width.
- TIMEOUT, 255, WAIT-state cycles before the read is re-issued; counter width $clog2(TIMEOUT+1).

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  reset; asynchronous, active-low.
- f2_miss_valid  in  1  F2 reports a miss this cycle.
- f2_miss_p_addr  in  ADDR_SZ  physical address of the missing fetch.
- f2_miss_v_addr  in  ADDR_SZ  virtual address of the missing fetch.
- f2_redirect  in  1  front-end flush/redirect; cancels the in-flight miss.
- mh_busy  out  1  stall to F1/F2; high in any state except IDLE.
- icache_l2_op  out  3  request op: 0 = NOP, 1 = R (the only op this block issues).
- icache_l2_addr  out  ADDR_SZ  line-aligned request address (low OFS bits zero).
- l2_icache_ready  in  1  L2 accepts the request this cycle.
- l2_icache_op  in  3  response op; 1 = R data return; all other values are ignored.
- l2_icache_addr  in  ADDR_SZ  response line address.
- l2_icache_data  in  CACHE_LINE  response line data.
- l2_icache_state  in  4  response coherence state.
- fill_valid  out  1  one-cycle pulse: install the line.
- fill_p_addr  out  ADDR_SZ  line-aligned fill address.
- fill_v_addr  out  ADDR_SZ  latched virtual address of the miss.
- fill_data  out  CACHE_LINE  fill line.
- fill_state  out  4  fill coherence state.
- fill_replay  out  1  with fill_valid: 1 = F2 replays the fetch; 0 = the miss was cancelled, install only.
- retry_cnt  out  4  number of timeout re-issues for the current miss; saturates at 15.

Behaviour:
- Reset (rst = 0, async): state = IDLE, and every output is 0: mh_busy, icache_l2_op, icache_l2_addr, fill_valid, fill_p_addr, fill_v_addr, fill_data, fill_state, fill_replay, retry_cnt. The cancel flag and timeout counter are also cleared.
- Reset mid-miss: the miss is abandoned. Any later L2 response arrives in IDLE and is ignored.

State machine (encoding IDLE, REQ, WAIT, FILL):
- IDLE:
  - On f2_miss_valid = 1 and f2_redirect = 0: latch line_addr = {p_addr[ADDR_SZ-1:OFS], OFS'b0} and v_addr. Clear cancel, retry_cnt and the timer. Go to REQ.
  - If f2_miss_valid and f2_redirect are high together, the redirect wins and the miss is dropped.
- REQ:
  - Drive icache_l2_op = 1 and icache_l2_addr = line_addr. Hold both stable until l2_icache_ready = 1.
  - On ready: go to WAIT next cycle; icache_l2_op returns to 0 that cycle. Clear the timer.
  - If f2_redirect = 1 in REQ and not on the first REQ issue: mark cancel, finish the request normally, and also mark cancel for any redirect later in the miss.
  - If f2_redirect = 1 in REQ on the first REQ issue before ready: go to IDLE with no request sent. Ready in that same cycle counts as a handshake and takes WAIT with cancel set.
- WAIT:
  - The timer increments every cycle.
  - On l2_icache_op = 1 and l2_icache_addr[ADDR_SZ-1:OFS] == line_addr[ADDR_SZ-1:OFS]: register data and state, go to FILL.
  - Non-matching or non-R responses are ignored.
  - When the timer reaches TIMEOUT with no match: retry_cnt++ (saturating), go to REQ.
  - A match on the same cycle as the timeout: the match wins.
  - f2_redirect: set cancel, stay in WAIT.
- FILL:
  - fill_valid = 1 for exactly one cycle. fill_p_addr = line_addr, fill_v_addr = latched v_addr, fill_replay = ~cancel. A redirect arriving in FILL also forces fill_replay = 0.
  - Go to IDLE next cycle. fill_data, fill_state and the addresses hold their values until the next fill.
- Latency: miss to request is 1 cycle; matching response to fill_valid is 1 cycle; fill_valid to mh_busy low is 1 cycle. mh_busy is registered.
- f2_miss_valid while busy is ignored; F2 must not change its miss while mh_busy = 1.

Test Plan:
- Basic miss: miss p_addr 0x0000_1234, ready at the first REQ cycle, response R at 0x0000_1200 three cycles later → icache_l2_addr = 0x0000_1200; fill_valid for 1 cycle with the data; fill_replay = 1; mh_busy falls the next cycle.
- Backpressure and mismatch: ready held low 4 cycles, then high; response R at 0x0000_1240 first, then 0x0000_1200 → op/addr stable for all 5 REQ cycles; the first response is ignored; the fill uses the second.
- Redirect: redirect during WAIT → fill_valid = 1, fill_replay = 0. Redirect in the first REQ cycle with ready = 0 → return to IDLE; icache_l2_op never equals 1 after that cycle.
- Timeout: no response for TIMEOUT = 255 WAIT cycles → request re-issued and retry_cnt = 1. Response after the re-issue → normal fill.
- Reset mid-WAIT: drop rst for 1 cycle → all outputs 0 immediately (async); a response arriving afterwards produces no fill_valid.
- Simultaneous miss and redirect in IDLE → stays in IDLE; mh_busy stays 0.
